btn_event_gen: RTL and testbench
================================

Name: btn_event_gen

Overview:
Consumes the 3-flop synchronised button level and turns it into the game-logic events the paddle and menu controllers need.
- Applies a stability (bounce) filter to produce a clean level.
- Emits one-cycle press/release pulses.
- Emits "step" pulses with hold-to-repeat auto-repeat for continuous paddle motion.
- One instance per button, placed between the synchroniser and the game FSM, all in the 100 MHz domain.

Parameters:
- STABLE_CYCLES, 1_000_000, consecutive cycles the input must differ from the filtered level before the level flips (10 ms); must be ≥2.
- REPEAT_DELAY, 30_000_000, cycles from filtered rise to the first auto-repeat step (300 ms); must be ≥2.
- REPEAT_PERIOD, 5_000_000, cycles between subsequent auto-repeat steps (50 ms); must be ≥2.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- btn_sync  in  1  already-synchronised raw button level
- btn_level  out  1  filtered (debounced) level
- press_pulse  out  1  one-cycle pulse on filtered 0->1
- release_pulse  out  1  one-cycle pulse on filtered 1->0
- step_pulse  out  1  one-cycle pulse: on press, then auto-repeat while held

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset: btn_level, press_pulse, release_pulse and step_pulse are 0. FSM goes to IDLE and all counters to 0. Reset dominates every other event in the same cycle.
- FSM states: IDLE (level 0), RISE_CHK (level 0, candidate high), HELD (level 1), FALL_CHK (level 1, candidate low).
- IDLE -> RISE_CHK when btn_sync=1.
  - RISE_CHK increments stab_cnt while btn_sync=1.
  - If btn_sync=0, return to IDLE with stab_cnt=0.
  - When btn_sync=1 and stab_cnt=STABLE_CYCLES-1, go to HELD and clear stab_cnt.
- HELD -> FALL_CHK when btn_sync=0. FALL_CHK mirrors RISE_CHK: it returns to HELD on btn_sync=1 and reaches IDLE after STABLE_CYCLES consecutive 0 samples.
- Latency: if btn_sync is 1 for samples k..k+N-1 with N≥STABLE_CYCLES, btn_level reads 1 from cycle k+STABLE_CYCLES. A run of STABLE_CYCLES-1 or fewer produces no output change. The same rule applies to the fall.
- press_pulse and step_pulse are asserted in the first cycle btn_level=1. release_pulse is asserted in the first cycle btn_level=0 after being 1. Each pulse lasts exactly one cycle.
- Auto-repeat:
  - rpt_cnt is 0 whenever btn_level=0.
  - rpt_cnt counts every cycle btn_level=1, including FALL_CHK cycles.
  - The first repeat step fires at cycle rise+REPEAT_DELAY. Further steps fire every REPEAT_PERIOD cycles until btn_level falls.
  - The counter reloads without drift. It never wraps while held: after the first repeat it counts modulo REPEAT_PERIOD.
- A repeat step due in the same cycle btn_level falls is suppressed; only release_pulse fires. press_pulse and release_pulse are never high together.
- Reset while held: outputs go to 0 the next cycle. If the button is still held after rst deasserts, the block treats it as a fresh press: press_pulse and step_pulse fire STABLE_CYCLES cycles later.
- Widths:
  - stab_cnt is $clog2(STABLE_CYCLES) bits.
  - rpt_cnt is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1) bits.
  - No arithmetic overflow is permitted.

Decomposition:
- Shared package/header pong_pkg:
  - 2-bit state encoding constants (BTN_IDLE, BTN_RISE_CHK, BTN_HELD, BTN_FALL_CHK).
  - Default timing constants BTN_STABLE_10MS, BTN_RPT_DELAY_300MS, BTN_RPT_PERIOD_50MS.
- One natural sub-module: btn_stab_filter, containing the FSM and stab_cnt. It outputs btn_level, rise and fall.
- The top level adds the rpt_cnt and pulse logic.

Test Plan (bench uses STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
1. btn_sync high 3 cycles, then low -> btn_level stays 0; no pulses at all.
2. btn_sync rises at cycle 10 and holds -> btn_level=1 from cycle 14; press_pulse and step_pulse high only in cycle 14.
3. Continue holding to cycle 30 -> step_pulse at cycles 24, 27 and 30 only; press_pulse not re-asserted.
4. Bounce 1,0,1,1,0 then steady 0 while held -> btn_level stays 1. After 4 consecutive 0 samples, btn_level=0 and release_pulse fires for one cycle; no step in that cycle even if due.
5. Assert rst for 2 cycles while filtered level is held high, btn_sync kept 1 -> all outputs 0 during reset. press_pulse re-fires 4 cycles after rst deasserts.
6. Release aligned so the falling transition coincides with a due repeat -> only release_pulse fires; step_pulse=0 in that cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared by the button event blocks.
// Holds the 2-bit debounce FSM state encoding, the default timing
// constants for a 100 MHz clock, and a small max helper used when
// sizing counters.
package pong_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE     = 2'd0,  // level 0, input agrees
    BTN_RISE_CHK = 2'd1,  // level 0, input high, qualifying
    BTN_HELD     = 2'd2,  // level 1, input agrees
    BTN_FALL_CHK = 2'd3   // level 1, input low, qualifying
  } btn_state_e;

  localparam int unsigned BTN_STABLE_10MS     = 1_000_000;
  localparam int unsigned BTN_RPT_DELAY_300MS = 30_000_000;
  localparam int unsigned BTN_RPT_PERIOD_50MS = 5_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_stab_filter.sv
// btn_stab_filter: stability filter for one synchronised button.
// The filtered level flips only after the input has disagreed with it
// for STABLE_CYCLES consecutive samples.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous, active-high reset
//   btn_sync  in  synchronised raw button level
//   btn_level out registered filtered level
//   rise      out strobe: btn_level becomes 1 at the next clock edge
//   fall      out strobe: btn_level becomes 0 at the next clock edge
// rise/fall are early (combinational) strobes so that the parent can
// register its pulses in the same cycle btn_level changes.
module btn_stab_filter
  import pong_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = BTN_STABLE_10MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sync,
  output logic btn_level,
  output logic rise,
  output logic fall
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);

  btn_state_e        state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              level_q, level_d;

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    rise       = 1'b0;
    fall       = 1'b0;
    case (state_q)
      // The first disagreeing sample already counts as one.
      BTN_IDLE: begin
        if (btn_sync) begin
          state_d    = BTN_RISE_CHK;
          stab_cnt_d = STAB_ONE;
        end
      end
      BTN_RISE_CHK: begin
        if (!btn_sync) begin
          state_d    = BTN_IDLE;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = BTN_HELD;
          stab_cnt_d = '0;
          rise       = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_ONE;
        end
      end
      BTN_HELD: begin
        if (!btn_sync) begin
          state_d    = BTN_FALL_CHK;
          stab_cnt_d = STAB_ONE;
        end
      end
      BTN_FALL_CHK: begin
        if (btn_sync) begin
          state_d    = BTN_HELD;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = BTN_IDLE;
          stab_cnt_d = '0;
          fall       = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_ONE;
        end
      end
      default: begin
        state_d    = BTN_IDLE;
        stab_cnt_d = '0;
      end
    endcase

    level_d = level_q;
    if (rise) level_d = 1'b1;
    if (fall) level_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BTN_IDLE;
      stab_cnt_q <= '0;
      level_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      level_q    <= level_d;
    end
  end

  assign btn_level = level_q;

endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: turns a synchronised button level into game events.
// Ports:
//   clk           in  100 MHz system clock
//   rst           in  synchronous, active-high reset
//   btn_sync      in  synchronised raw button level
//   btn_level     out filtered (debounced) level
//   press_pulse   out one-cycle pulse on filtered 0->1
//   release_pulse out one-cycle pulse on filtered 1->0
//   step_pulse    out one-cycle pulse on press, then auto-repeat while held
// All outputs are registered.
module btn_event_gen
  import pong_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = BTN_STABLE_10MS,
  parameter int unsigned REPEAT_DELAY  = BTN_RPT_DELAY_300MS,
  parameter int unsigned REPEAT_PERIOD = BTN_RPT_PERIOD_50MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sync,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

  logic level, rise, fall;

  btn_stab_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .btn_sync (btn_sync),
    .btn_level(level),
    .rise     (rise),
    .fall     (fall)
  );

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_phase_q, rpt_phase_d;  // 1 once the first repeat has fired
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;
  logic             rpt_due;

  always_comb begin
    // Counter holds cycle index since rise (or since last repeat); a step
    // registered now lands exactly REPEAT_DELAY / REPEAT_PERIOD after.
    rpt_due = level && (rpt_phase_q ? (rpt_cnt_q == PERIOD_LAST)
                                    : (rpt_cnt_q == DELAY_LAST));
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    if (!level || fall) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (rpt_due) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b1;
    end else begin
      rpt_cnt_d   = rpt_cnt_q + RPT_ONE;
    end

    press_d   = rise;
    release_d = fall;
    // A repeat landing on the falling edge is dropped.
    step_d    = rise || (rpt_due && !fall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
      press_q     <= press_d;
      release_q   <= release_d;
      step_q      <= step_d;
    end
  end

  assign btn_level     = level;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen with short timing (4/10/3). A behavioural model
// tracks the filtered level from run lengths of disagreeing samples and
// derives pulses from the age of the current hold.
module tb_btn_event_gen;

  localparam int S = 4;
  localparam int D = 10;
  localparam int P = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_sync = 1'b0;
  logic btn_level, press_pulse, release_pulse, step_pulse;

  btn_event_gen #(
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (D),
    .REPEAT_PERIOD(P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_sync     (btn_sync),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  bit chk_en = 1'b0;

  // Reference model state (values for the current cycle)
  bit m_lvl, m_press, m_rel, m_step;
  int m_run, m_age;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic model_edge(input bit x, input bit r);
    bit old;
    old = m_lvl;
    if (r) begin
      m_lvl = 0; m_press = 0; m_rel = 0; m_step = 0; m_run = 0; m_age = 0;
    end else begin
      if (x != m_lvl) begin
        m_run++;
        if (m_run == S) begin
          m_lvl = x;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_press = m_lvl && !old;
      m_rel   = !m_lvl && old;
      if (m_press)    m_age = 0;
      else if (m_lvl) m_age++;
      else            m_age = 0;
      m_step = m_press || (m_lvl && m_age >= D && ((m_age - D) % P) == 0);
    end
  endtask

  // One clock cycle: check current outputs, drive next inputs, advance model.
  task automatic cyc(input bit x, input bit r);
    @(negedge clk);
    if (chk_en) begin
      check_eq("btn_level", btn_level, m_lvl);
      check_eq("press_pulse", press_pulse, m_press);
      check_eq("release_pulse", release_pulse, m_rel);
      check_eq("step_pulse", step_pulse, m_step);
      check_eq("press_rel_excl", press_pulse & release_pulse, 1'b0);
    end
    btn_sync = x;
    rst = r;
    @(posedge clk);
    model_edge(x, r);
    cyc_n++;
  endtask

  task automatic run(input bit x, input int n);
    for (int i = 0; i < n; i++) cyc(x, 1'b0);
  endtask

  initial begin
    m_lvl = 0; m_press = 0; m_rel = 0; m_step = 0; m_run = 0; m_age = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    chk_en = 1'b1;

    // Short glitch: no output activity
    run(1'b0, 5);
    run(1'b1, S - 1);
    run(1'b0, 6);

    // Clean press and hold through three repeats
    run(1'b1, S + D + 2 * P + 3);

    // Bouncy release while held, then steady low
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    run(1'b0, 8);

    // Reset while held, button stays down
    run(1'b1, S + 8);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
    run(1'b1, S + 4);
    run(1'b0, S + 3);

    // Release timed so the fall lands on a due repeat (rise+D+P)
    run(1'b1, S + D + P - S);
    run(1'b0, S + 4);

    // Release timed on the first repeat (rise+D)
    run(1'b1, D);
    run(1'b0, S + 4);

    // Randomised runs with occasional reset
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 2)); j++)
          cyc(1'($urandom_range(0, 1)), 1'b1);
      end
      run(1'(k % 2), int'($urandom_range(1, 2 * S + D)));
    end
    run(1'b0, S + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
